// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and flow-control unit for the five-stage pipeline: operand forwarding,
// load-use stall sequencing, delay-slot annul and saturating debug counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             ID_uses_rd,
  input  logic             ID_branch,
  input  logic             ID_branch_always,
  input  logic             ID_cond_true,
  input  logic             ID_annul,
  input  logic [4:0]       EX_RD,
  input  logic [4:0]       MEM_RD,
  input  logic [4:0]       WB_RD,
  input  logic             EX_RF_LE,
  input  logic             MEM_RF_LE,
  input  logic             WB_RF_LE,
  input  logic             EX_load,
  output logic [1:0]       fwd_sel_rs1,
  output logic [1:0]       fwd_sel_rs2,
  output logic [1:0]       fwd_sel_rd,
  output logic             PC_LE,
  output logic             nPC_LE,
  output logic             IF_ID_LE,
  output logic             ID_EX_clr,
  output logic             IF_ID_clr,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] annul_count
);

  typedef enum logic {RUN, LOAD_STALL} state_t;

  state_t state, state_nxt;
  logic   hz, an, ld_match;

  function automatic logic [1:0] fwd(
    input logic [4:0] src,   input logic used,
    input logic [4:0] ex_rd, input logic ex_le,
    input logic [4:0] mem_rd, input logic mem_le,
    input logic [4:0] wb_rd, input logic wb_le
  );
    fwd = 2'b00;
    if (used && src != 5'd0) begin
      if (ex_le && ex_rd == src)        fwd = 2'b01;
      else if (mem_le && mem_rd == src) fwd = 2'b10;
      else if (wb_le && wb_rd == src)   fwd = 2'b11;
    end
  endfunction

  always_comb begin
    ld_match = (ID_uses_rs1 && ID_rs1 == EX_RD) ||
               (ID_uses_rs2 && ID_rs2 == EX_RD) ||
               (ID_uses_rd  && ID_rd  == EX_RD);
    hz = EX_load && EX_RF_LE && (EX_RD != 5'd0) && ld_match;
    an = ID_branch && ID_annul && (ID_branch_always || !ID_cond_true);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Both states behave identically on hz: a back-to-back hazard re-enters LOAD_STALL.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:        state_nxt = hz ? LOAD_STALL : RUN;
      LOAD_STALL: state_nxt = hz ? LOAD_STALL : RUN;
      default:    state_nxt = RUN;
    endcase
  end

  always_comb begin
    fwd_sel_rs1  = 2'b00;
    fwd_sel_rs2  = 2'b00;
    fwd_sel_rd   = 2'b00;
    PC_LE        = 1'b0;
    nPC_LE       = 1'b0;
    IF_ID_LE     = 1'b0;
    ID_EX_clr    = 1'b1;
    IF_ID_clr    = 1'b1;
    stall_active = (state == LOAD_STALL);
    if (reset) begin
      fwd_sel_rs1 = fwd(ID_rs1, ID_uses_rs1, EX_RD, EX_RF_LE, MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE);
      fwd_sel_rs2 = fwd(ID_rs2, ID_uses_rs2, EX_RD, EX_RF_LE, MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE);
      fwd_sel_rd  = fwd(ID_rd,  ID_uses_rd,  EX_RD, EX_RF_LE, MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE);
      if (hz) begin
        IF_ID_clr = 1'b0;
      end else begin
        PC_LE     = 1'b1;
        nPC_LE    = 1'b1;
        IF_ID_LE  = 1'b1;
        ID_EX_clr = 1'b0;
        IF_ID_clr = an;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      annul_count <= '0;
    end else begin
      if (hz && stall_count != '1)        stall_count <= stall_count + 1'b1;
      if (IF_ID_clr && annul_count != '1) annul_count <= annul_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// stimulus compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned CNT_W = 16;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [4:0] ID_rs1, ID_rs2, ID_rd, EX_RD, MEM_RD, WB_RD;
  logic ID_uses_rs1, ID_uses_rs2, ID_uses_rd;
  logic ID_branch, ID_branch_always, ID_cond_true, ID_annul;
  logic EX_RF_LE, MEM_RF_LE, WB_RF_LE, EX_load;
  logic [1:0] fwd_sel_rs1, fwd_sel_rs2, fwd_sel_rd;
  logic PC_LE, nPC_LE, IF_ID_LE, ID_EX_clr, IF_ID_clr, stall_active;
  logic [CNT_W-1:0] stall_count, annul_count;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .ID_uses_rd(ID_uses_rd),
    .ID_branch(ID_branch), .ID_branch_always(ID_branch_always),
    .ID_cond_true(ID_cond_true), .ID_annul(ID_annul),
    .EX_RD(EX_RD), .MEM_RD(MEM_RD), .WB_RD(WB_RD),
    .EX_RF_LE(EX_RF_LE), .MEM_RF_LE(MEM_RF_LE), .WB_RF_LE(WB_RF_LE),
    .EX_load(EX_load),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2), .fwd_sel_rd(fwd_sel_rd),
    .PC_LE(PC_LE), .nPC_LE(nPC_LE), .IF_ID_LE(IF_ID_LE),
    .ID_EX_clr(ID_EX_clr), .IF_ID_clr(IF_ID_clr),
    .stall_active(stall_active), .stall_count(stall_count), .annul_count(annul_count)
  );

  int errors = 0;
  int checks = 0;
  int m_stall = 0;
  int m_annul = 0;
  bit m_sa = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: search stages youngest-first for a live write to the source.
  function automatic int m_fwd(input logic [4:0] src, input logic used);
    logic [4:0] rd [3];
    logic       le [3];
    rd[0] = EX_RD;  le[0] = EX_RF_LE;
    rd[1] = MEM_RD; le[1] = MEM_RF_LE;
    rd[2] = WB_RD;  le[2] = WB_RF_LE;
    if (!used || src == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (le[i] && rd[i] == src) return i + 1;
    return 0;
  endfunction

  function automatic bit m_hz();
    bit dep = (ID_uses_rs1 && ID_rs1 == EX_RD) || (ID_uses_rs2 && ID_rs2 == EX_RD) ||
              (ID_uses_rd && ID_rd == EX_RD);
    return EX_load && EX_RF_LE && EX_RD != 0 && dep;
  endfunction

  function automatic bit m_an();
    return ID_branch && ID_annul && (ID_branch_always || !ID_cond_true);
  endfunction

  task automatic check_all();
    bit h = m_hz();
    bit a = m_an();
    if (!rst_n) begin
      chk("rst_fwd1", fwd_sel_rs1, 0); chk("rst_fwd2", fwd_sel_rs2, 0); chk("rst_fwdd", fwd_sel_rd, 0);
      chk("rst_pc", PC_LE, 0); chk("rst_npc", nPC_LE, 0); chk("rst_ifid_le", IF_ID_LE, 0);
      chk("rst_idex_clr", ID_EX_clr, 1); chk("rst_ifid_clr", IF_ID_clr, 1);
    end else begin
      chk("fwd1", fwd_sel_rs1, m_fwd(ID_rs1, ID_uses_rs1));
      chk("fwd2", fwd_sel_rs2, m_fwd(ID_rs2, ID_uses_rs2));
      chk("fwdd", fwd_sel_rd,  m_fwd(ID_rd,  ID_uses_rd));
      chk("pc_le", PC_LE, !h); chk("npc_le", nPC_LE, !h); chk("ifid_le", IF_ID_LE, !h);
      chk("idex_clr", ID_EX_clr, h); chk("ifid_clr", IF_ID_clr, a && !h);
    end
    chk("stall_active", stall_active, m_sa);
    chk("stall_count", stall_count, m_stall);
    chk("annul_count", annul_count, m_annul);
  endtask

  task automatic cycle();
    bit h, a;
    @(negedge clk);
    check_all();
    h = m_hz();
    a = m_an();
    @(posedge clk);
    if (rst_n) begin
      if (h) m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
      if (a && !h) m_annul = (m_annul < MAXC) ? m_annul + 1 : MAXC;
      m_sa = h;
    end
    #1;
  endtask

  task automatic clear_inputs();
    {ID_rs1, ID_rs2, ID_rd, EX_RD, MEM_RD, WB_RD} = '0;
    {ID_uses_rs1, ID_uses_rs2, ID_uses_rd} = '0;
    {ID_branch, ID_branch_always, ID_cond_true, ID_annul} = '0;
    {EX_RF_LE, MEM_RF_LE, WB_RF_LE, EX_load} = '0;
  endtask

  task automatic rand_inputs();
    ID_rs1 = 5'($urandom_range(3)); ID_rs2 = 5'($urandom_range(3)); ID_rd = 5'($urandom_range(3));
    EX_RD = 5'($urandom_range(3)); MEM_RD = 5'($urandom_range(3)); WB_RD = 5'($urandom_range(3));
    {ID_uses_rs1, ID_uses_rs2, ID_uses_rd} = 3'($urandom);
    {ID_branch, ID_branch_always, ID_cond_true, ID_annul} = 4'($urandom);
    {EX_RF_LE, MEM_RF_LE, WB_RF_LE, EX_load} = 4'($urandom);
  endtask

  initial begin
    // 1: reset with arbitrary inputs, then release
    rst_n = 1'b0;
    rand_inputs();
    #2;
    chk("t1_pc", PC_LE, 0); chk("t1_idex", ID_EX_clr, 1); chk("t1_ifid", IF_ID_clr, 1);
    chk("t1_scnt", stall_count, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    clear_inputs();
    #2;
    chk("t1_rel_pc", PC_LE, 1); chk("t1_rel_idex", ID_EX_clr, 0); chk("t1_rel_ifid", IF_ID_clr, 0);
    cycle();

    // 2: forwarding priority
    ID_rs1 = 5; ID_uses_rs1 = 1; EX_RD = 5; EX_RF_LE = 1; MEM_RD = 5; MEM_RF_LE = 1;
    #2 chk("t2_ex", fwd_sel_rs1, 2'b01); cycle();
    EX_RF_LE = 0;
    #2 chk("t2_mem", fwd_sel_rs1, 2'b10); cycle();
    MEM_RF_LE = 0; WB_RD = 5; WB_RF_LE = 1;
    #2 chk("t2_wb", fwd_sel_rs1, 2'b11); cycle();
    ID_rs1 = 0;
    #2 chk("t2_r0", fwd_sel_rs1, 2'b00); cycle();

    // 3: load-use stall, then forward from MEM
    clear_inputs();
    EX_load = 1; EX_RD = 7; EX_RF_LE = 1; ID_rs2 = 7; ID_uses_rs2 = 1;
    #2 chk("t3_pc", PC_LE, 0); chk("t3_idex", ID_EX_clr, 1);
    cycle();
    chk("t3_scnt", stall_count, 1); chk("t3_sa", stall_active, 1);
    EX_load = 0; EX_RF_LE = 0; MEM_RD = 7; MEM_RF_LE = 1;
    #2 chk("t3_fwd", fwd_sel_rs2, 2'b10); chk("t3_le", PC_LE, 1);
    cycle();
    chk("t3_sa_end", stall_active, 0);

    // 4: annul cases
    clear_inputs();
    ID_branch = 1; ID_cond_true = 0; ID_annul = 1;
    #2 chk("t4_untaken", IF_ID_clr, 1); cycle();
    chk("t4_acnt", annul_count, 1);
    ID_cond_true = 1;
    #2 chk("t4_taken", IF_ID_clr, 0); cycle();
    ID_branch_always = 1;
    #2 chk("t4_ba", IF_ID_clr, 1); cycle();
    chk("t4_acnt2", annul_count, 2);

    // 5: stall beats annul, branch re-evaluated afterwards
    clear_inputs();
    ID_branch = 1; ID_annul = 1; ID_cond_true = 0;
    EX_load = 1; EX_RD = 3; EX_RF_LE = 1; ID_rs1 = 3; ID_uses_rs1 = 1;
    #2 chk("t5_clr", IF_ID_clr, 0); chk("t5_idex", ID_EX_clr, 1);
    cycle();
    chk("t5_sa", stall_active, 1);
    EX_load = 0; EX_RF_LE = 0;
    #2 chk("t5_reeval", IF_ID_clr, 1);
    cycle();

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    // 6: saturation, then reset mid-stall
    clear_inputs();
    EX_load = 1; EX_RD = 9; EX_RF_LE = 1; ID_rd = 9; ID_uses_rd = 1;
    repeat ((1 << CNT_W) + 3) cycle();
    chk("t6_sat", stall_count, MAXC);
    chk("t6_sa", stall_active, 1);
    #2 rst_n = 1'b0;
    m_stall = 0; m_annul = 0; m_sa = 1'b0;
    #1;
    chk("t6_rst_sa", stall_active, 0); chk("t6_rst_scnt", stall_count, 0);
    chk("t6_rst_acnt", annul_count, 0); chk("t6_rst_pc", PC_LE, 0);
    cycle();
    rst_n = 1'b1;
    clear_inputs();
    cycle();
    chk("t6_run", stall_active, 0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
